// File: rtl/divisor_programable_pkg.sv
// Shared definitions for the programmable clock divider and the PWM blocks:
// output-mode encodings and the post-reset terminal count.
package divisor_programable_pkg;

    typedef enum logic [0:0] {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    // Terminal count after reset (100 MHz / (2 * 32051) ~= 1.56 kHz square wave)
    localparam int DEFAULT_DIV = 32050;

endpackage : divisor_programable_pkg

// File: rtl/divisor_programable_if.sv
// Control/status bundle of the programmable clock divider.
// slave  : the divider side (takes controls, drives outputs)
// master : the controller side (drives controls, observes outputs)
interface divisor_programable_if #(
    parameter int WIDTH = 16
) ();

    logic             enable;
    logic             load;
    logic [WIDTH-1:0] divisor;
    logic             mode;
    logic             clock_out;
    logic             tick_out;
    logic             pend_out;

    modport slave (
        input  enable,
        input  load,
        input  divisor,
        input  mode,
        output clock_out,
        output tick_out,
        output pend_out
    );

    modport master (
        output enable,
        output load,
        output divisor,
        output mode,
        input  clock_out,
        input  tick_out,
        input  pend_out
    );

endinterface : divisor_programable_if

// File: rtl/divisor_programable_contador_modulo.sv
// WIDTH-bit modulo counter: counts 0..i_limit while enabled, then wraps to 0.
// o_wrap flags the enabled cycle in which the wrap happens. Clear has
// priority over counting; the >= compare keeps the count bounded even if
// the limit is ever lowered underneath a running count.
module contador_modulo #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_limit,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_wrap
);

    logic [WIDTH-1:0] r_cnt;
    logic             w_at_limit;

    assign w_at_limit = (r_cnt >= i_limit);
    assign o_wrap     = i_enable & w_at_limit;
    assign o_cnt      = r_cnt;

    // Count register: reset/clear to zero, increment or wrap when enabled, else hold
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= {WIDTH{1'b0}};
        end else if (i_clear) begin
            r_cnt <= {WIDTH{1'b0}};
        end else if (i_enable) begin
            if (w_at_limit) begin
                r_cnt <= {WIDTH{1'b0}};
            end else begin
                r_cnt <= r_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule : contador_modulo

// File: rtl/divisor_programable.sv
// Programmable clock divider. A modulo counter runs 0..D_act; each wrap
// either toggles Clock_out (square wave) or pulses it for one cycle.
// New settings loaded while running are held pending and take effect at
// the next wrap so periods are never truncated; loads while stopped apply
// at once.
module divisor_programable #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = divisor_programable_pkg::DEFAULT_DIV
) (
    input logic                  i_clock_in,
    input logic                  i_reset,
    divisor_programable_if.slave i_bus
);

    import divisor_programable_pkg::*;

    localparam logic [WIDTH-1:0] LP_DEFAULT_DIV = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] w_cnt;
    logic             w_wrap;
    logic             w_clear;
    logic [WIDTH-1:0] w_d_next;
    mode_e            w_m_next;
    mode_e            w_mode_in;

    logic [WIDTH-1:0] r_d_act;
    mode_e            r_m_act;
    logic [WIDTH-1:0] r_d_pend;
    mode_e            r_m_pend;
    logic             r_pend_valid;
    logic             r_clock_out;
    logic             r_tick_out;

    assign w_mode_in = mode_e'(i_bus.mode);
    // A load while stopped restarts the period from zero
    assign w_clear   = ~i_bus.enable & i_bus.load;

    contador_modulo #(
        .WIDTH (WIDTH)
    ) u_contador (
        .i_clk    (i_clock_in),
        .i_reset  (i_reset),
        .i_enable (i_bus.enable),
        .i_clear  (w_clear),
        .i_limit  (r_d_act),
        .o_cnt    (w_cnt),
        .o_wrap   (w_wrap)
    );

    // Setting that becomes active at a wrap: a same-cycle load beats an older pending one
    always_comb begin
        w_d_next = r_d_act;
        w_m_next = r_m_act;
        if (i_bus.load) begin
            w_d_next = i_bus.divisor;
            w_m_next = w_mode_in;
        end else if (r_pend_valid) begin
            w_d_next = r_d_pend;
            w_m_next = r_m_pend;
        end else begin
            w_d_next = r_d_act;
            w_m_next = r_m_act;
        end
    end

    // Active/pending settings and registered outputs
    always_ff @(posedge i_clock_in) begin
        if (i_reset) begin
            r_d_act      <= LP_DEFAULT_DIV;
            r_m_act      <= MODE_TOGGLE;
            r_d_pend     <= {WIDTH{1'b0}};
            r_m_pend     <= MODE_TOGGLE;
            r_pend_valid <= 1'b0;
            r_clock_out  <= 1'b0;
            r_tick_out   <= 1'b0;
        end else if (!i_bus.enable) begin
            r_tick_out <= 1'b0;
            if (i_bus.load) begin
                r_d_act      <= i_bus.divisor;
                r_m_act      <= w_mode_in;
                r_pend_valid <= 1'b0;
                r_clock_out  <= 1'b0;
            end else begin
                r_clock_out  <= r_clock_out;
            end
        end else if (w_wrap) begin
            r_tick_out   <= 1'b1;
            r_d_act      <= w_d_next;
            r_m_act      <= w_m_next;
            r_pend_valid <= 1'b0;
            // Pulse mode is high on the wrap; leaving pulse mode counts that
            // high as the first toggle-mode inversion
            if ((w_m_next == MODE_PULSE) || (r_m_act == MODE_PULSE)) begin
                r_clock_out <= 1'b1;
            end else begin
                r_clock_out <= ~r_clock_out;
            end
        end else begin
            r_tick_out <= 1'b0;
            if (r_m_act == MODE_PULSE) begin
                r_clock_out <= 1'b0;
            end else begin
                r_clock_out <= r_clock_out;
            end
            if (i_bus.load) begin
                r_d_pend     <= i_bus.divisor;
                r_m_pend     <= w_mode_in;
                r_pend_valid <= 1'b1;
            end else begin
                r_pend_valid <= r_pend_valid;
            end
        end
    end

    assign i_bus.clock_out = r_clock_out;
    assign i_bus.tick_out  = r_tick_out;
    assign i_bus.pend_out  = r_pend_valid;

endmodule : divisor_programable
